// File: rtl/seq_pkg.sv
// seq_pkg: state encodings, opcode constants and error codes shared by the multi-cycle sequencer
package seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_TMO   = 2'b01;
  localparam logic [1:0] ERR_ILL   = 2'b10;
  function automatic logic op_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};
  endfunction
endpackage

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: instruction/data memory handshake bundle
// master = sequencer (drives req/ir_write/we), slave = memory side (drives ready)
interface multicycle_sequencer_if;
  logic imem_req;
  logic imem_ready;
  logic ir_write;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;
  modport master (output imem_req, ir_write, dmem_req, dmem_we, input imem_ready, dmem_ready);
  modport slave  (input imem_req, ir_write, dmem_req, dmem_we, output imem_ready, dmem_ready);
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts request cycles without ready, flags the MEM_TIMEOUT-th one
// ports: clk, rst (async high), clear (restart at 0), count_en (req without ready), expired
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : count_en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  // cnt_q holds the number of earlier stalled cycles, so this is the MEM_TIMEOUT-th one
  assign expired = count_en && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: phase FSM gating RV32I decode strobes into one-phase-at-a-time enables
// ports: clk, rst (async high), start, halt_req, opcode, dec_* strobes, branch_taken,
//        mem (imem/dmem handshake), reg_we, pc_write, pc_sel, busy, trap, err_code, state_o, instret
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          halt_req,
  input  logic [6:0]                    opcode,
  input  logic                          dec_memread,
  input  logic                          dec_memwrite,
  input  logic                          dec_regwrite,
  input  logic                          dec_branch,
  input  logic                          branch_taken,
  multicycle_sequencer_if.master        mem,
  output logic                          reg_we,
  output logic                          pc_write,
  output logic                          pc_sel,
  output logic                          busy,
  output logic                          trap,
  output logic [1:0]                    err_code,
  output logic [2:0]                    state_o,
  output logic [31:0]                   instret
);
  state_t      state_q, state_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] instret_q, instret_d;
  logic        retire, expired, wait_en, wait_clr;
  // FETCH and MEM never overlap, so one timer serves both
  assign wait_en  = (state_q == S_FETCH && !mem.imem_ready) || (state_q == S_MEM && !mem.dmem_ready);
  assign wait_clr = (state_d == S_FETCH || state_d == S_MEM) && state_d != state_q;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (wait_clr),
    .count_en (wait_en),
    .expired  (expired)
  );
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    retire       = 1'b0;
    mem.imem_req = 1'b0;
    mem.ir_write = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    reg_we       = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    case (state_q)
      S_IDLE: state_d = start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem.imem_req = 1'b1;
        mem.ir_write = mem.imem_ready;
        if (mem.imem_ready) state_d = S_DECODE;
        else if (expired) begin
          state_d = S_TRAP;
          err_d   = ERR_TMO;
        end
      end
      S_DECODE:
        if (op_legal(opcode)) state_d = S_EXEC;
        else begin
          state_d = S_TRAP;
          err_d   = ERR_ILL;
        end
      S_EXEC:
        if (dec_branch) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken;
          retire   = 1'b1;
        end else state_d = (dec_memread || dec_memwrite) ? S_MEM : S_WB;
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = dec_memwrite;
        if (mem.dmem_ready) begin
          if (dec_memwrite) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end else state_d = S_WB;
        end else if (expired) begin
          state_d = S_TRAP;
          err_d   = ERR_TMO;
        end
      end
      S_WB: begin
        reg_we   = dec_regwrite;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
    if (retire) state_d = halt_req ? S_IDLE : S_FETCH;
    instret_d = instret_q + 32'(retire);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= S_IDLE;
      err_q     <= ERR_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      instret_q <= instret_d;
    end
  assign busy     = state_q != S_IDLE && state_q != S_TRAP;
  assign trap     = state_q == S_TRAP;
  assign err_code = err_q;
  assign state_o  = state_q;
  assign instret  = instret_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: table-driven cycle vectors plus directed trap/timeout/reset sequences
module tb_multicycle_sequencer;
  import seq_pkg::*;
  logic        clk = 1'b0, rst = 1'b1;
  logic        start, halt_req, dec_memread, dec_memwrite, dec_regwrite, dec_branch, branch_taken;
  logic [6:0]  opcode;
  logic        reg_we, pc_write, pc_sel, busy, trap;
  logic [1:0]  err_code;
  logic [2:0]  state_o;
  logic [31:0] instret;
  int          nvec = 0, nerr = 0;
  multicycle_sequencer_if bus();
  multicycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .halt_req     (halt_req),
    .opcode       (opcode),
    .dec_memread  (dec_memread),
    .dec_memwrite (dec_memwrite),
    .dec_regwrite (dec_regwrite),
    .dec_branch   (dec_branch),
    .branch_taken (branch_taken),
    .mem          (bus),
    .reg_we       (reg_we),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .busy         (busy),
    .trap         (trap),
    .err_code     (err_code),
    .state_o      (state_o),
    .instret      (instret)
  );
  always #5 clk = ~clk;
  // dec = {memread, memwrite, regwrite, branch}
  // stb = {imem_req, ir_write, dmem_req, dmem_we, reg_we, pc_write, pc_sel}
  typedef struct {
    logic        s, h;
    logic [6:0]  op;
    logic [3:0]  dec;
    logic        bt, ir, dr;
    logic [2:0]  st;
    logic [6:0]  stb;
    logic        bsy;
    logic [31:0] cnt;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(input logic s, h, input logic [6:0] op, input logic [3:0] dec,
                              input logic bt, ir, dr, input logic [2:0] st, input logic [6:0] stb,
                              input logic bsy, input logic [31:0] cnt);
    vec_t v;
    v.s = s; v.h = h; v.op = op; v.dec = dec; v.bt = bt; v.ir = ir; v.dr = dr;
    v.st = st; v.stb = stb; v.bsy = bsy; v.cnt = cnt;
    return v;
  endfunction
  task automatic drv(input logic s, h, input logic [6:0] op, input logic [3:0] dec, input logic bt, ir, dr);
    start = s; halt_req = h; opcode = op;
    {dec_memread, dec_memwrite, dec_regwrite, dec_branch} = dec;
    branch_taken = bt; bus.imem_ready = ir; bus.dmem_ready = dr;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [2:0] st, input logic [6:0] stb, input logic bsy, trp,
                     input logic [1:0] err, input logic [31:0] cnt);
    logic [45:0] e, a;
    e = {st, stb, bsy, trp, err, cnt};
    a = {state_o, bus.imem_req, bus.ir_write, bus.dmem_req, bus.dmem_we, reg_we, pc_write, pc_sel,
         busy, trap, err_code, instret};
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got st=%0d stb=%b busy=%b trap=%b err=%b instret=%0d, want st=%0d stb=%b busy=%b trap=%b err=%b instret=%0d",
               nm, a[45:43], a[42:36], a[35], a[34], a[33:32], a[31:0], st, stb, bsy, trp, err, cnt);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask
  initial begin
    drv(0, 0, OP_R, 4'b0000, 0, 0, 0);
    tick;
    tick;
    chk("reset", 3'd0, 7'b0, 0, 0, ERR_NONE, 0);
    rst = 1'b0;
    // R-type, zero wait
    tv.push_back(mk(1, 0, OP_R, 4'b0010, 0, 1, 0, 3'd0, 7'b0000000, 0, 0));
    tv.push_back(mk(0, 0, OP_R, 4'b0010, 0, 1, 0, 3'd1, 7'b1100000, 1, 0));
    tv.push_back(mk(1, 0, OP_R, 4'b0010, 0, 1, 0, 3'd2, 7'b0000000, 1, 0));
    tv.push_back(mk(0, 0, OP_R, 4'b0010, 0, 1, 0, 3'd3, 7'b0000000, 1, 0));
    tv.push_back(mk(0, 0, OP_R, 4'b0010, 0, 1, 0, 3'd5, 7'b0000110, 1, 0));
    // load, dmem_ready three cycles after dmem_req rises
    tv.push_back(mk(0, 0, OP_LOAD, 4'b1010, 0, 1, 0, 3'd1, 7'b1100000, 1, 1));
    tv.push_back(mk(0, 0, OP_LOAD, 4'b1010, 0, 1, 0, 3'd2, 7'b0000000, 1, 1));
    tv.push_back(mk(0, 0, OP_LOAD, 4'b1010, 0, 1, 0, 3'd3, 7'b0000000, 1, 1));
    tv.push_back(mk(0, 0, OP_LOAD, 4'b1010, 0, 1, 0, 3'd4, 7'b0010000, 1, 1));
    tv.push_back(mk(0, 0, OP_LOAD, 4'b1010, 0, 1, 0, 3'd4, 7'b0010000, 1, 1));
    tv.push_back(mk(0, 0, OP_LOAD, 4'b1010, 0, 1, 0, 3'd4, 7'b0010000, 1, 1));
    tv.push_back(mk(0, 0, OP_LOAD, 4'b1010, 0, 1, 1, 3'd4, 7'b0010000, 1, 1));
    tv.push_back(mk(0, 0, OP_LOAD, 4'b1010, 0, 1, 1, 3'd5, 7'b0000110, 1, 1));
    // taken branch
    tv.push_back(mk(0, 0, OP_BRANCH, 4'b0001, 1, 1, 0, 3'd1, 7'b1100000, 1, 2));
    tv.push_back(mk(0, 0, OP_BRANCH, 4'b0001, 1, 1, 0, 3'd2, 7'b0000000, 1, 2));
    tv.push_back(mk(0, 0, OP_BRANCH, 4'b0001, 1, 1, 0, 3'd3, 7'b0000011, 1, 2));
    // untaken branch, halt_req outside retire must be ignored
    tv.push_back(mk(0, 1, OP_BRANCH, 4'b0001, 0, 1, 0, 3'd1, 7'b1100000, 1, 3));
    tv.push_back(mk(0, 1, OP_BRANCH, 4'b0001, 0, 1, 0, 3'd2, 7'b0000000, 1, 3));
    tv.push_back(mk(0, 0, OP_BRANCH, 4'b0001, 0, 1, 0, 3'd3, 7'b0000010, 1, 3));
    // store, halt at retire
    tv.push_back(mk(0, 0, OP_STORE, 4'b0100, 0, 1, 1, 3'd1, 7'b1100000, 1, 4));
    tv.push_back(mk(0, 0, OP_STORE, 4'b0100, 0, 1, 1, 3'd2, 7'b0000000, 1, 4));
    tv.push_back(mk(0, 0, OP_STORE, 4'b0100, 0, 1, 1, 3'd3, 7'b0000000, 1, 4));
    tv.push_back(mk(0, 1, OP_STORE, 4'b0100, 0, 1, 1, 3'd4, 7'b0011010, 1, 4));
    tv.push_back(mk(0, 0, OP_R, 4'b0010, 0, 1, 1, 3'd0, 7'b0000000, 0, 5));
    tv.push_back(mk(0, 0, OP_R, 4'b0010, 0, 1, 1, 3'd0, 7'b0000000, 0, 5));
    foreach (tv[i]) begin
      drv(tv[i].s, tv[i].h, tv[i].op, tv[i].dec, tv[i].bt, tv[i].ir, tv[i].dr);
      @(negedge clk);
      chk($sformatf("vec%0d", i), tv[i].st, tv[i].stb, tv[i].bsy, 1'b0, ERR_NONE, tv[i].cnt);
      tick;
    end
    // illegal opcode traps after DECODE and stays there
    do_reset;
    drv(1, 0, 7'b1101111, 4'b0000, 0, 1, 0);
    tick;
    tick;
    @(negedge clk);
    chk("ill_decode", 3'd2, 7'b0, 1, 0, ERR_NONE, 0);
    tick;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ill_trap%0d", k), 3'd7, 7'b0, 0, 1, ERR_ILL, 0);
      tick;
    end
    #2 rst = 1'b1;
    #1 chk("trap_rst", 3'd0, 7'b0, 0, 0, ERR_NONE, 0);
    tick;
    rst = 1'b0;
    // fetch timeout on the 16th stalled cycle
    drv(1, 0, OP_R, 4'b0010, 0, 0, 0);
    tick;
    for (int k = 0; k < 15; k++) tick;
    @(negedge clk);
    chk("tmo_f16", 3'd1, 7'b1000000, 1, 0, ERR_NONE, 0);
    tick;
    @(negedge clk);
    chk("tmo_trap", 3'd7, 7'b0, 0, 1, ERR_TMO, 0);
    // ready on the 16th cycle wins
    do_reset;
    drv(1, 0, OP_R, 4'b0010, 0, 0, 0);
    tick;
    for (int k = 0; k < 15; k++) tick;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    chk("rdy_f16", 3'd1, 7'b1100000, 1, 0, ERR_NONE, 0);
    tick;
    @(negedge clk);
    chk("rdy_decode", 3'd2, 7'b0, 1, 0, ERR_NONE, 0);
    // data memory timeout, counter restarted on MEM entry
    drv(0, 0, OP_LOAD, 4'b1010, 0, 0, 0);
    tick;
    tick;
    for (int k = 0; k < 15; k++) tick;
    @(negedge clk);
    chk("mtmo_m16", 3'd4, 7'b0010000, 1, 0, ERR_NONE, 0);
    tick;
    @(negedge clk);
    chk("mtmo_trap", 3'd7, 7'b0, 0, 1, ERR_TMO, 0);
    // reset in the middle of a stalled store
    do_reset;
    drv(1, 1, OP_STORE, 4'b0100, 0, 1, 0);
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    @(negedge clk);
    chk("st_mem", 3'd4, 7'b0011000, 1, 0, ERR_NONE, 0);
    #2 rst = 1'b1;
    #1 chk("mid_rst", 3'd0, 7'b0, 0, 0, ERR_NONE, 0);
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_hold", 3'd0, 7'b0, 0, 0, ERR_NONE, 0);
    tick;
    rst = 1'b0;
    // rerun R-type with halt at retire
    drv(1, 1, OP_R, 4'b0010, 0, 1, 0);
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    @(negedge clk);
    chk("halt_wb", 3'd5, 7'b0000110, 1, 0, ERR_NONE, 0);
    tick;
    @(negedge clk);
    chk("halt_idle", 3'd0, 7'b0, 0, 0, ERR_NONE, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Phase sequencer that turns the single-cycle RV32I datapath into a multi-cycle machine with handshaked instruction and data memories. It takes the opcode and the combinational decode strobes (memread, memwrite, regwrite, branch). It gates them into one-phase-at-a-time enables for the IR, register file, data memory and PC. It also adds memory-wait timeouts, an illegal-opcode trap, halt support and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, number of request cycles without ready before TRAP (legal range 2..255)
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  leave IDLE and begin fetching
halt_req  in  1  sampled at retire; 1 = return to IDLE instead of FETCH
opcode  in  7  instr[6:0] from IR
dec_memread  in  1  decoder load strobe
dec_memwrite  in  1  decoder store strobe
dec_regwrite  in  1  decoder register-write strobe
dec_branch  in  1  decoder branch strobe
branch_taken  in  1  branch comparison result from ALU, valid in EXEC
imem_req  out  1  instruction fetch request
imem_ready  in  1  instruction memory data valid
ir_write  out  1  load IR
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write enable, qualified by dmem_req
dmem_ready  in  1  data memory access complete
reg_we  out  1  register file write enable
pc_write  out  1  update PC
pc_sel  out  1  0 = PC+4, 1 = branch target; meaningful only when pc_write=1
busy  out  1  state not IDLE and not TRAP
trap  out  1  sticky fault indicator
err_code  out  2  00 none, 01 memory timeout, 10 illegal opcode
state_o  out  3  current state, for debug
instret  out  32  retired-instruction count

Behaviour:
- One clock domain. Reset is asynchronous and active-high. The state register, wait counter, err_code and instret are registered.
- Strobes are combinational from state and inputs, with no latch.
- On reset: state=IDLE, err_code=00, instret=0, wait counter=0. All strobes 0, busy=0, trap=0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
- IDLE: all strobes 0. Goes to FETCH on start=1.
- FETCH: imem_req=1.
  - On imem_ready=1: ir_write=1 in the same cycle, then go to DECODE.
- DECODE: one cycle, no strobes.
  - Supported opcodes: 0110011, 0010011, 0000011, 0100011, 1100011. These go to EXEC.
  - Any other opcode: go to TRAP with err_code=10.
- EXEC: one cycle.
  - dec_branch=1: pc_write=1, pc_sel=branch_taken, retire, leave the instruction.
  - dec_memread=1 or dec_memwrite=1: go to MEM.
  - Otherwise: go to WB.
- MEM: dmem_req=1, dmem_we=dec_memwrite. Held stable until dmem_ready.
  - On ready, store: pc_write=1, retire.
  - On ready, load: go to WB.
- WB: reg_we=dec_regwrite, pc_write=1, pc_sel=0, retire.
- Retire (same cycle as the final pc_write):
  - instret += 1, wrapping from 0xFFFFFFFF to 0.
  - Next state = IDLE if halt_req=1, else FETCH.
- Zero-wait latencies:
  - R/I-type: 4 cycles (F, D, E, W).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each req cycle with ready=0.
  - If ready=0 on the MEM_TIMEOUT-th consecutive req cycle: go to TRAP, err_code=01.
  - Ready on that same cycle wins and there is no trap.
- TRAP: trap=1, all strobes 0. Sticky; the only exit is rst.
- start is ignored outside IDLE. halt_req is ignored except at retire.
- Reset mid-MEM: dmem_req drops asynchronously and no partial write strobe is issued afterwards. instret is not incremented.

Decomposition:
- Shared package seq_pkg holds:
  - state encodings
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH
  - error codes: ERR_NONE, ERR_TMO, ERR_ILL
- One sub-module, mem_wait_timer (clear, count_en, expired), instantiated once and shared by FETCH and MEM. The two states are mutually exclusive.

Test Plan:
- R-type: start=1, opcode=0110011, dec_regwrite=1, zero-wait memory -> ir_write in cycle 1; reg_we and pc_write (pc_sel=0) in cycle 4; instret=1; back to FETCH.
- Load: opcode=0000011, dmem_ready asserted 3 cycles after dmem_req rises -> dmem_req high 4 cycles with dmem_we=0; then WB with reg_we=1; total 8 cycles.
- Taken branch: opcode=1100011, branch_taken=1 -> pc_write=1, pc_sel=1 in EXEC (cycle 3); no reg_we, no dmem_req.
- Illegal opcode 1101111 -> TRAP after DECODE, err_code=10, trap=1; start and imem_ready pulses have no effect until rst.
- FETCH timeout: imem_ready held 0 with MEM_TIMEOUT=16 -> TRAP on cycle 16, err_code=01. A second run with ready on cycle 16 -> DECODE, no trap.
- rst pulsed mid-MEM store with halt_req=1 at a later retire -> immediate IDLE with all outputs 0 and instret unchanged. Rerun: halt_req=1 at retire -> IDLE, busy=0.
